hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Hazard control for the 5-stage RISC-V pipeline.
- Generates the 2-bit forwarding selects that drive the execute-stage operand muxes (mux_3, sel input).
- Generates stall and flush controls for load-use hazards and taken branches/jumps.
- Holds the pipeline through multi-cycle data-memory accesses using a small FSM with a timeout counter.

Parameters:
- REG_ADDR_W, 5, register index width
- MEM_TIMEOUT, 64, maximum data-memory wait cycles before abort (≥2)
- CNT_W, 32, stall counter width (optional feature only)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rs1_d, rs2_d  in  REG_ADDR_W  source registers of the instruction in D
- rs1_e, rs2_e  in  REG_ADDR_W  source registers of the instruction in E
- rd_e  in  REG_ADDR_W  destination register in E
- rd_m, rd_w  in  REG_ADDR_W  destination registers in M and W
- reg_write_m, reg_write_w  in  1  register-write enables in M and W
- result_src_e0  in  1  instruction in E is a load
- pc_src_e  in  1  taken branch or jump resolved in E
- dmem_req_m  in  1  load or store active in M
- dmem_ready  in  1  data memory completes this cycle
- forward_a_e, forward_b_e  out  2  operand select: 00 regfile, 01 result_w, 10 alu_result_m
- stall_f, stall_d, stall_e, stall_m  out  1  hold the stage register
- flush_d, flush_e, flush_w  out  1  bubble the stage register
- mem_err  out  1  one-cycle pulse on memory timeout

Behaviour:
- Reset: clk and rst as above; reset is asynchronous and active-high (already decided).
  - While rst=1: all outputs 0, forward selects 00, FSM in RUN, counters 0.
- Forwarding (combinational, evaluated per operand X∈{1,2}):
  - 10 if reg_write_m && rd_m!=0 && rd_m==rsX_e.
  - else 01 if reg_write_w && rd_w!=0 && rd_w==rsX_e.
  - else 00.
  - M has priority over W.
  - Encoding 11 is never produced.
- Load-use detection: lw_stall = result_src_e0 && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d).
- FSM states: RUN, MEM_WAIT, ABORT.
  - RUN → MEM_WAIT when dmem_req_m && !dmem_ready; load wait_cnt=1.
  - MEM_WAIT → RUN when dmem_ready.
  - MEM_WAIT → ABORT when wait_cnt==MEM_TIMEOUT-1 && !dmem_ready; otherwise wait_cnt increments.
  - ABORT → RUN unconditionally after 1 cycle; mem_err=1 for that cycle only.
- Stall/flush in RUN, with no memory stall in progress:
  - stall_f = stall_d = lw_stall && !pc_src_e.
  - flush_e = lw_stall || pc_src_e.
  - flush_d = pc_src_e.
  - stall_e = stall_m = flush_w = 0.
- Memory stall, asserted when (RUN && dmem_req_m && !dmem_ready) or in MEM_WAIT:
  - stall_f, stall_d, stall_e, stall_m = 1; flush_w = 1.
  - flush_d = flush_e = 0: a pending branch or load-use is held, not lost, and re-evaluated on release.
  - The memory stall is combinational in the first cycle (no extra latency).
  - The release cycle (dmem_ready=1) behaves as RUN.
- ABORT: all stalls 0; flush_d, flush_e, flush_w = 1, discarding in-flight work.
- dmem_ready=1 while dmem_req_m=0 is ignored.
- Reset mid-wait: FSM returns to RUN immediately, with no mem_err pulse.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - Adds outputs stall_cycles and flush_cycles (CNT_W each).
  - stall_cycles increments every cycle stall_f=1; flush_cycles increments every cycle flush_e=1.
  - Both saturate at all-ones and reset to 0.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package riscv_pkg:
  - fwd_sel_t enum (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10).
  - haz_state_t enum (RUN, MEM_WAIT, ABORT).
  - REG_ADDR_W constant.
- Sub-module fwd_select: combinational forwarding logic for one operand, instantiated twice (A and B).

Test Plan:
- Forwarding priority:
  - reg_write_m=1, rd_m=5, reg_write_w=1, rd_w=5, rs1_e=5 → forward_a_e=10.
  - Drop reg_write_m → 01.
  - rd_m=0, rs1_e=0 → 00.
- Load-use: result_src_e0=1, rd_e=7, rs2_d=7 → stall_f=stall_d=flush_e=1 for 1 cycle, flush_d=0; with rd_e=0 → no stall.
- Branch: pc_src_e=1 → flush_d=flush_e=1, stall_f=0; also pc_src_e=1 with lw_stall=1 → stall_f=0.
- Memory wait: dmem_req_m=1, dmem_ready low for 3 cycles then high → stalls F/D/E/M and flush_w high for exactly 3 cycles; pc_src_e=1 during the wait gives flush_d=0 until release, then 1.
- Timeout with MEM_TIMEOUT=4, dmem_ready never high:
  - stalls for 4 cycles, then mem_err=1 and flush_d/e/w=1 for 1 cycle, then RUN.
  - rst asserted in cycle 2 of the wait → all outputs 0 asynchronously, no mem_err.
- With HAZARD_PERF_CNT_EN defined:
  - 3 load-use events plus a 3-cycle memory wait → stall_cycles=6, flush_cycles=3.
  - Counters preloaded near all-ones saturate and do not wrap.

Source files
------------

// File: rtl/riscv_pkg.sv
//==============================================================================
// Module      : riscv_pkg
// Description : Shared types and constants for the 5-stage RISC-V pipeline
//               hazard control: forwarding select encoding, hazard FSM states
//               and the register index width.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package riscv_pkg;

  localparam int REG_ADDR_W = 5;

  // Execute-stage operand mux select. The value 2'b11 is never generated.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,   // register file value
    FWD_WB  = 2'b01,   // result_w from writeback
    FWD_MEM = 2'b10    // alu_result_m from memory stage
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ABORT    = 2'b10
  } haz_state_t;

endpackage

`default_nettype wire

// File: rtl/hazard_unit_fwd_select.sv
//==============================================================================
// Module      : fwd_select
// Description : Forwarding select for one execute-stage operand. The memory
//               stage producer wins over the writeback stage producer; x0 is
//               never forwarded.
// Ports       : rs_e_i        - source register of the operand in E
//               rd_m_i/rd_w_i - destination registers in M and W
//               reg_write_m_i/reg_write_w_i - write enables in M and W
//               sel_o         - operand mux select
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fwd_select #(
  parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] rs_e_i,
  input  logic [REG_ADDR_W-1:0] rd_m_i,
  input  logic [REG_ADDR_W-1:0] rd_w_i,
  input  logic                  reg_write_m_i,
  input  logic                  reg_write_w_i,
  output riscv_pkg::fwd_sel_t   sel_o
);

  import riscv_pkg::*;

  always_comb begin
    sel_o = FWD_RF;
    if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i)) begin
      sel_o = FWD_MEM;
    end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
//==============================================================================
// Module      : hazard_unit
// Description : Hazard control for the 5-stage RISC-V pipeline. Produces the
//               execute-stage forwarding selects, load-use and branch
//               stall/flush controls, and holds the pipeline through
//               multi-cycle data-memory accesses with a timeout abort.
// Ports       : clk, rst (async, active-high)
//               rs1_d/rs2_d, rs1_e/rs2_e, rd_e, rd_m, rd_w - register indices
//               reg_write_m/w, result_src_e0, pc_src_e, dmem_req_m, dmem_ready
//               forward_a_e/forward_b_e - operand selects
//               stall_f/d/e/m, flush_d/e/w - stage register controls
//               mem_err - one-cycle pulse on memory timeout
//               stall_cycles/flush_cycles - only with HAZARD_PERF_CNT_EN
// Options     : define HAZARD_PERF_CNT_EN to add saturating stall/flush
//               cycle counters.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hazard_unit #(
  parameter int REG_ADDR_W  = riscv_pkg::REG_ADDR_W,
  parameter int MEM_TIMEOUT = 64
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rs1_e,
  input  logic [REG_ADDR_W-1:0] rs2_e,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  reg_write_m,
  input  logic                  reg_write_w,
  input  logic                  result_src_e0,
  input  logic                  pc_src_e,
  input  logic                  dmem_req_m,
  input  logic                  dmem_ready,
  output logic [1:0]            forward_a_e,
  output logic [1:0]            forward_b_e,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  stall_m,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  flush_w,
  output logic                  mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_cycles
`endif
);

  import riscv_pkg::*;

  localparam int WCNT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  fwd_sel_t          fwd_a;
  fwd_sel_t          fwd_b;
  haz_state_t        state_q;
  logic [WCNT_W-1:0] wait_cnt_q;
  logic              mem_err_q;
  logic              lw_stall;
  logic              mem_stall;

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs_e_i        (rs1_e),
    .rd_m_i        (rd_m),
    .rd_w_i        (rd_w),
    .reg_write_m_i (reg_write_m),
    .reg_write_w_i (reg_write_w),
    .sel_o         (fwd_a)
  );

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs_e_i        (rs2_e),
    .rd_m_i        (rd_m),
    .rd_w_i        (rd_w),
    .reg_write_m_i (reg_write_m),
    .reg_write_w_i (reg_write_w),
    .sel_o         (fwd_b)
  );

  assign lw_stall = result_src_e0 && (rd_e != '0) &&
                    ((rd_e == rs1_d) || (rd_e == rs2_d));

  // The first wait cycle is taken combinationally from RUN so the pipeline
  // freezes with no added latency. A MEM_WAIT cycle with dmem_ready high is
  // the release cycle and behaves like RUN.
  assign mem_stall = ((state_q == RUN) && dmem_req_m && !dmem_ready) ||
                     ((state_q == MEM_WAIT) && !dmem_ready);

  // wait_cnt counts stalled cycles of the current access; reaching
  // MEM_TIMEOUT-1 while still not ready means MEM_TIMEOUT cycles have stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      mem_err_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (dmem_req_m && !dmem_ready) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= WCNT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == WCNT_LAST) begin
            state_q    <= ABORT;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WCNT_W'(1);
          end
        end
        default: begin
          state_q    <= RUN;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  // Every output is forced low while rst is high, independent of the clock.
  always_comb begin
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    stall_m     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_w     = 1'b0;
    mem_err     = 1'b0;
    if (!rst) begin
      forward_a_e = fwd_a;
      forward_b_e = fwd_b;
      if (state_q == ABORT) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
        flush_w = 1'b1;
        mem_err = mem_err_q;
      end else if (mem_stall) begin
        // Branch and load-use flushes are withheld so they are re-evaluated
        // once memory releases the pipeline.
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else begin
        stall_f = lw_stall && !pc_src_e;
        stall_d = lw_stall && !pc_src_e;
        flush_e = lw_stall || pc_src_e;
        flush_d = pc_src_e;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_f && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_e && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_cycles = flush_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
//==============================================================================
// Module      : tb_hazard_unit
// Description : Self-checking bench for hazard_unit: directed scenarios with
//               literal expectations plus randomized traffic compared every
//               cycle against a behavioural model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_hazard_unit;

  localparam int RW      = 5;
  localparam int TIMEOUT = 4;
  localparam int TB_CNT_W = 4;

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic sf, sd, se, sm;
    logic fd, fe, fw;
    logic err;
  } out_t;

  logic          clk;
  logic          rst;
  logic [RW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic          reg_write_m, reg_write_w, result_src_e0, pc_src_e;
  logic          dmem_req_m, dmem_ready;
  logic [1:0]    forward_a_e, forward_b_e;
  logic          stall_f, stall_d, stall_e, stall_m;
  logic          flush_d, flush_e, flush_w, mem_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [TB_CNT_W-1:0] stall_cycles, flush_cycles;
`endif

  int total = 0;
  int bad   = 0;

  hazard_unit #(
    .REG_ADDR_W  (RW),
    .MEM_TIMEOUT (TIMEOUT)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .CNT_W       (TB_CNT_W)
`endif
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rs1_d         (rs1_d),
    .rs2_d         (rs2_d),
    .rs1_e         (rs1_e),
    .rs2_e         (rs2_e),
    .rd_e          (rd_e),
    .rd_m          (rd_m),
    .rd_w          (rd_w),
    .reg_write_m   (reg_write_m),
    .reg_write_w   (reg_write_w),
    .result_src_e0 (result_src_e0),
    .pc_src_e      (pc_src_e),
    .dmem_req_m    (dmem_req_m),
    .dmem_ready    (dmem_ready),
    .forward_a_e   (forward_a_e),
    .forward_b_e   (forward_b_e),
    .stall_f       (stall_f),
    .stall_d       (stall_d),
    .stall_e       (stall_e),
    .stall_m       (stall_m),
    .flush_d       (flush_d),
    .flush_e       (flush_e),
    .flush_w       (flush_w),
    .mem_err       (mem_err)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles  (stall_cycles),
    .flush_cycles  (flush_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic out_t dut_vec();
    out_t o;
    o.fa = forward_a_e; o.fb = forward_b_e;
    o.sf = stall_f; o.sd = stall_d; o.se = stall_e; o.sm = stall_m;
    o.fd = flush_d; o.fe = flush_e; o.fw = flush_w; o.err = mem_err;
    return o;
  endfunction

  // ---------------- behavioural model ----------------
  int  stall_run  = 0;   // consecutive cycles the current access has stalled
  bit  abort_next = 1'b0;
  logic [TB_CNT_W-1:0] m_stall_cnt = '0;
  logic [TB_CNT_W-1:0] m_flush_cnt = '0;

  function automatic logic [1:0] fwd(input logic [RW-1:0] rs);
    if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
    if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit mem_stalling();
    if (stall_run > 0) return !dmem_ready;
    return dmem_req_m && !dmem_ready;
  endfunction

  function automatic out_t model_out();
    out_t o;
    bit   lw;
    o = '0;
    if (rst) return o;
    o.fa = fwd(rs1_e);
    o.fb = fwd(rs2_e);
    lw = result_src_e0 && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    if (abort_next) begin
      o.fd = 1; o.fe = 1; o.fw = 1; o.err = 1;
    end else if (mem_stalling()) begin
      o.sf = 1; o.sd = 1; o.se = 1; o.sm = 1; o.fw = 1;
    end else begin
      o.sf = lw && !pc_src_e;
      o.sd = lw && !pc_src_e;
      o.fe = lw || pc_src_e;
      o.fd = pc_src_e;
    end
    return o;
  endfunction

  always @(posedge clk) begin
    out_t o;
    if (rst) begin
      stall_run = 0; abort_next = 0; m_stall_cnt = '0; m_flush_cnt = '0;
    end else begin
      o = model_out();
      if (o.sf && m_stall_cnt != '1) m_stall_cnt = m_stall_cnt + 1'b1;
      if (o.fe && m_flush_cnt != '1) m_flush_cnt = m_flush_cnt + 1'b1;
      if (abort_next) begin
        abort_next = 0;
        stall_run  = 0;
      end else if (mem_stalling()) begin
        stall_run++;
        if (stall_run == TIMEOUT) begin
          abort_next = 1;
          stall_run  = 0;
        end
      end else begin
        stall_run = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("outputs", 32'(dut_vec()), 32'(model_out()));
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cycles", 32'(stall_cycles), 32'(m_stall_cnt));
    check("flush_cycles", 32'(flush_cycles), 32'(m_flush_cnt));
`endif
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    reg_write_m = 0; reg_write_w = 0; result_src_e0 = 0; pc_src_e = 0;
    dmem_req_m = 0; dmem_ready = 0;
  endtask

  initial begin
    out_t v;
    rst = 1'b1;
    idle();
    reg_write_m = 1; rd_m = 5; rs1_e = 5;
    #3;
    check("reset_zero", 32'(dut_vec()), 32'd0);
    tick();
    rst = 1'b0;
    idle();
    tick();

    // Forwarding priority
    reg_write_m = 1; rd_m = 5; reg_write_w = 1; rd_w = 5; rs1_e = 5;
    #2 check("fwd_mem", 32'(forward_a_e), 32'b10);
    tick();
    reg_write_m = 0;
    #2 check("fwd_wb", 32'(forward_a_e), 32'b01);
    tick();
    reg_write_m = 1; rd_m = 0; rs1_e = 0; rd_w = 5;
    #2 check("fwd_x0", 32'(forward_a_e), 32'b00);
    tick();
    idle();
    reg_write_w = 1; rd_w = 9; rs2_e = 9;
    #2 check("fwd_b_wb", 32'(forward_b_e), 32'b01);
    tick();

    // Load-use
    idle();
    result_src_e0 = 1; rd_e = 7; rs2_d = 7;
    #2 check("lw_stall", 32'({stall_f, stall_d, flush_e, flush_d}), 32'b1110);
    tick();
    idle();
    #2 check("lw_released", 32'({stall_f, stall_d, flush_e}), 32'b000);
    tick();
    result_src_e0 = 1; rd_e = 0; rs2_d = 0;
    #2 check("lw_x0", 32'({stall_f, stall_d, flush_e}), 32'b000);
    tick();

    // Branch, alone and over a load-use
    idle();
    pc_src_e = 1;
    #2 check("branch", 32'({flush_d, flush_e, stall_f}), 32'b110);
    tick();
    result_src_e0 = 1; rd_e = 7; rs1_d = 7;
    #2 check("branch_lw", 32'({flush_d, flush_e, stall_f, stall_d}), 32'b1100);
    tick();

    // Memory wait of 3 cycles with a branch pending
    idle();
    dmem_req_m = 1; pc_src_e = 1;
    for (int i = 0; i < 3; i++) begin
      #2 check("mem_wait", 32'({stall_f, stall_d, stall_e, stall_m, flush_w, flush_d, flush_e}),
               32'b1111100);
      tick();
    end
    dmem_ready = 1;
    #2 check("mem_release", 32'({stall_f, stall_d, stall_e, stall_m, flush_w, flush_d, flush_e}),
             32'b0000011);
    tick();

    // Timeout
    idle();
    dmem_req_m = 1;
    for (int i = 0; i < TIMEOUT; i++) begin
      #2 check("timeout_wait", 32'({stall_f, stall_e, mem_err}), 32'b110);
      tick();
    end
    #2 check("abort", 32'({mem_err, flush_d, flush_e, flush_w, stall_f, stall_m}), 32'b111100);
    idle();
    tick();
    #2 check("after_abort", 32'(dut_vec()), 32'd0);
    tick();

    // Reset in the middle of a wait
    dmem_req_m = 1;
    tick();
    tick();
    reg_write_m = 1; rd_m = 3; rs1_e = 3;
    #2 rst = 1'b1;
    #1 check("rst_midwait", 32'(dut_vec()), 32'd0);
    tick();
    rst = 1'b0;
    idle();
    for (int i = 0; i < 6; i++) begin
      #2 check("no_err_after_rst", 32'(mem_err), 32'd0);
      tick();
    end

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 299) == 0);
      rs1_d         = RW'($urandom_range(0, 3));
      rs2_d         = RW'($urandom_range(0, 3));
      rs1_e         = RW'($urandom_range(0, 3));
      rs2_e         = RW'($urandom_range(0, 3));
      rd_e          = RW'($urandom_range(0, 3));
      rd_m          = RW'($urandom_range(0, 3));
      rd_w          = RW'($urandom_range(0, 3));
      reg_write_m   = 1'($urandom_range(0, 1));
      reg_write_w   = 1'($urandom_range(0, 1));
      result_src_e0 = 1'($urandom_range(0, 1));
      pc_src_e      = ($urandom_range(0, 3) == 0);
      dmem_req_m    = 1'($urandom_range(0, 1));
      dmem_ready    = ($urandom_range(0, 9) < 3);
      tick();
    end
    rst = 1'b0;
    idle();
    tick();
    tick();
    v = dut_vec();
    check("final_idle", 32'(v), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
